// File: rtl/clk_switch_ctrl.sv
// Break-before-make gate sequencer for a four-input ICG clock mux; one gate open at most.
// Optional build macro CLK_SWITCH_LOCK_EN adds the sel_lock input that freezes source selection.
module clk_switch_ctrl #(
  parameter logic [1:0]  RESET_SEL     = 2'b00,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] clk_sel_req,
  input  logic       req_valid,
`ifdef CLK_SWITCH_LOCK_EN
  input  logic       sel_lock,
`endif
  output logic [3:0] gate_en,
  output logic [1:0] clk_sel_active,
  output logic       busy,
  output logic       switch_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_OPEN  = 2'd2;

  localparam logic [7:0] GAP_LOAD    = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_gap_bad
    $error("clk_switch_ctrl: GAP_CYCLES must be within 1..255");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_settle_bad
    $error("clk_switch_ctrl: SETTLE_CYCLES must be within 1..255");
  end

  logic lock_w;
`ifdef CLK_SWITCH_LOCK_EN
  assign lock_w = sel_lock;
`else
  assign lock_w = 1'b0;
`endif

  // Reset asserts asynchronously but is released only on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic [1:0] state_q,  state_d;
  logic [7:0] cnt_q,    cnt_d;
  logic [1:0] target_q, target_d;
  logic [1:0] active_q, active_d;
  logic [3:0] gate_q,   gate_d;
  logic       busy_q,   busy_d;
  logic       done_q,   done_d;
  logic       pend_vld_q, pend_vld_d;
  logic [1:0] pend_sel_q, pend_sel_d;

  logic       take_vld;
  logic [1:0] take_sel;

  // A live strobe always takes precedence over the stored pending request.
  assign take_vld = req_valid | pend_vld_q;
  assign take_sel = req_valid ? clk_sel_req : pend_sel_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    active_d   = active_q;
    gate_d     = gate_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pend_vld_d = pend_vld_q;
    pend_sel_d = pend_sel_q;

    if (state_q != ST_IDLE && req_valid) begin
      pend_vld_d = 1'b1;
      pend_sel_d = clk_sel_req;
    end

    case (state_q)
      ST_IDLE: begin
        pend_vld_d = 1'b0;
        busy_d     = 1'b0;
        if (!lock_w && take_vld && take_sel != active_q) begin
          target_d = take_sel;
          gate_d   = 4'b0000;
          busy_d   = 1'b1;
          cnt_d    = GAP_LOAD;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 8'd0) begin
          gate_d   = 4'(4'b0001 << target_q);
          active_d = target_q;
          cnt_d    = SETTLE_LOAD;
          state_d  = ST_OPEN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_OPEN: begin
        if (cnt_q == 8'd0) begin
          done_d  = 1'b1;
          busy_d  = pend_vld_d;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gate_d  = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      target_q   <= RESET_SEL;
      active_q   <= RESET_SEL;
      gate_q     <= 4'(4'b0001 << RESET_SEL);
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_sel_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      active_q   <= active_d;
      gate_q     <= gate_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pend_vld_q <= pend_vld_d;
      pend_sel_q <= pend_sel_d;
    end
  end

  assign gate_en        = gate_q;
  assign clk_sel_active = active_q;
  assign busy           = busy_q;
  assign switch_done    = done_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl: scoreboard of expected switch completions plus per-cycle checks.
module tb_clk_switch_ctrl;

  localparam int GAP    = 4;
  localparam int SETTLE = 2;
  localparam int LAT    = GAP + SETTLE + 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] clk_sel_req;
  logic       req_valid;
`ifdef CLK_SWITCH_LOCK_EN
  logic       sel_lock;
`endif
  logic [3:0] gate_en;
  logic [1:0] clk_sel_active;
  logic       busy;
  logic       switch_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [1:0] sel;
    int         done_cyc;
  } exp_t;
  exp_t sb_q[$];

  clk_switch_ctrl #(
    .RESET_SEL    (2'b00),
    .GAP_CYCLES   (GAP),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clk_sel_req   (clk_sel_req),
    .req_valid     (req_valid),
`ifdef CLK_SWITCH_LOCK_EN
    .sel_lock      (sel_lock),
`endif
    .gate_en       (gate_en),
    .clk_sel_active(clk_sel_active),
    .busy          (busy),
    .switch_done   (switch_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h required=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drive_req(input logic [1:0] s);
    req_valid   = 1'b1;
    clk_sel_req = s;
  endtask

  task automatic push_exp(input logic [1:0] s, input int done_at);
    exp_t e;
    e.sel      = s;
    e.done_cyc = done_at;
    sb_q.push_back(e);
  endtask

  // Monitor: one-hot-or-zero invariant each cycle and scoreboard pop on every switch_done.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert ($onehot0(gate_en)) else begin
        errors++;
        $error("FAIL onehot0 cyc=%0d observed=%b required=onehot0", cyc, gate_en);
      end
      if (switch_done === 1'b1) begin
        checks++;
        assert (sb_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_done cyc=%0d observed=pulse required=none", cyc);
        end
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          checks++;
          assert (clk_sel_active === e.sel) else begin
            errors++;
            $error("FAIL done_sel cyc=%0d observed=%0d required=%0d", cyc, clk_sel_active, e.sel);
          end
          checks++;
          assert (cyc === e.done_cyc) else begin
            errors++;
            $error("FAIL done_cycle observed=%0d required=%0d", cyc, e.done_cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d observed=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    clk_sel_req = 2'b00;
`ifdef CLK_SWITCH_LOCK_EN
    sel_lock    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_gate", 32'(gate_en), 32'h1);
    chk("rst_active", 32'(clk_sel_active), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(switch_done), 32'h0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Test 1: reset selection held while idle
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t1_gate", 32'(gate_en), 32'h1);
      chk("t1_busy", 32'(busy), 32'h0);
    end

    // Test 2: single switch 0 -> 2, exact gap and completion timing
    c = cyc;
    drive_req(2'b10);
    push_exp(2'b10, c + LAT);
    for (int k = 1; k <= LAT; k++) begin
      step();
      chk("t2_gate", 32'(gate_en), (k <= GAP) ? 32'h0 : 32'h4);
      chk("t2_busy", 32'(busy), (k < LAT) ? 32'h1 : 32'h0);
      chk("t2_done", 32'(switch_done), (k == LAT) ? 32'h1 : 32'h0);
    end
    chk("t2_active", 32'(clk_sel_active), 32'h2);

    // Test 4: request for the already-active source is ignored
    step();
    drive_req(2'b10);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t4_gate", 32'(gate_en), 32'h4);
      chk("t4_busy", 32'(busy), 32'h0);
      chk("t4_done", 32'(switch_done), 32'h0);
    end

    // Return to source 0 before the pending-request scenario
    c = cyc;
    drive_req(2'b00);
    push_exp(2'b00, c + LAT);
    repeat (LAT + 1) step();
    chk("back0_gate", 32'(gate_en), 32'h1);

    // Test 3: req 3 during DRAIN, req 1 during OPEN -> switch to 2, then to 1
    c = cyc;
    drive_req(2'b10);
    push_exp(2'b10, c + LAT);
    step();
    drive_req(2'b11);
    repeat (GAP) step();
    chk("t3_open_gate", 32'(gate_en), 32'h4);
    drive_req(2'b01);
    push_exp(2'b01, c + LAT + LAT);
    repeat (LAT - GAP - 1) step();
    chk("t3_first_done", 32'(switch_done), 32'h1);
    chk("t3_busy_held", 32'(busy), 32'h1);
    step();
    chk("t3_gap_gate", 32'(gate_en), 32'h0);
    repeat (LAT) step();
    chk("t3_final_gate", 32'(gate_en), 32'h2);
    chk("t3_final_active", 32'(clk_sel_active), 32'h1);
    chk("t3_final_busy", 32'(busy), 32'h0);
    chk("t3_sb_empty", 32'(sb_q.size()), 32'h0);

    // Test 5: reset during DRAIN with a pending request
    drive_req(2'b11);
    step();
    drive_req(2'b10);
    step();
    chk("t5_drain_gate", 32'(gate_en), 32'h0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_gate", 32'(gate_en), 32'h1);
    chk("t5_rst_active", 32'(clk_sel_active), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      chk("t5_gate", 32'(gate_en), 32'h1);
      chk("t5_busy", 32'(busy), 32'h0);
    end

`ifdef CLK_SWITCH_LOCK_EN
    // Test 6: locked selection ignores requests
    sel_lock = 1'b1;
    drive_req(2'b11);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t6_gate", 32'(gate_en), 32'h1);
      chk("t6_busy", 32'(busy), 32'h0);
    end
    sel_lock = 1'b0;
    step();
`endif

    chk("sb_empty_end", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
